// File: rtl/sb_pkg.sv
// Shared sideband definitions: packet width and the TX arbiter state encoding.
package sb_pkg;

  localparam int SB_PKT_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sb_tx_arb_state_e;

endpackage

// File: rtl/sb_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping at NUM_REQ-1 -> 0. Shared with the sideband RX dispatcher.
module sb_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      winner,
  output logic               any_valid
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[IW'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        winner    = IW'((int'(rr_ptr) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter in front of the sideband TX serializer with a post-accept idle gap.
// Define SB_TX_ARB_PRIO_EN to give requester 0 strict priority over the round-robin set.
module sb_tx_arbiter
  import sb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int WIDTH      = SB_PKT_WIDTH,
  parameter int GAP_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           ser_data,
  output logic                       ser_valid,
  input  logic                       ser_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);
`ifdef SB_TX_ARB_PRIO_EN
  localparam logic [IW-1:0] RR_BASE = IW'(1);
`else
  localparam logic [IW-1:0] RR_BASE = '0;
`endif

  sb_tx_arb_state_e state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] ser_data_q, ser_data_d;
  logic [IW-1:0]    grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [IW-1:0]      pick_win, win, rr_adv;
  logic               pick_any, any_valid;

`ifdef SB_TX_ARB_PRIO_EN
  // Requester 0 is kept out of the rotation; rr_ptr only ever points at 1..NUM_REQ-1.
  assign pick_req  = {req_valid[NUM_REQ-1:1], 1'b0};
  assign win       = req_valid[0] ? '0 : pick_win;
  assign any_valid = req_valid[0] | pick_any;
  assign rr_adv    = (win == '0) ? rr_ptr_q : ((win == LAST_REQ) ? RR_BASE : win + IW'(1));
`else
  assign pick_req  = req_valid;
  assign win       = pick_win;
  assign any_valid = pick_any;
  assign rr_adv    = (win == LAST_REQ) ? RR_BASE : win + IW'(1);
`endif

  sb_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req       (pick_req),
    .rr_ptr    (rr_ptr_q),
    .winner    (pick_win),
    .any_valid (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gap_cnt_d  = gap_cnt_q;
    ser_data_d = ser_data_q;
    grant_id_d = grant_id_q;
    req_ready  = '0;
    unique case (state_q)
      IDLE: begin
        // Ready is held off while reset is asserted so every output reads as reset.
        if (any_valid && !rst) begin
          req_ready[win] = 1'b1;
          ser_data_d     = req_data[int'(win)*WIDTH +: WIDTH];
          grant_id_d     = win;
          rr_ptr_d       = rr_adv;
          state_d        = GRANT;
        end
      end
      GRANT: begin
        if (ser_ready) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= RR_BASE;
      gap_cnt_q  <= '0;
      ser_data_q <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gap_cnt_q  <= gap_cnt_d;
      ser_data_q <= ser_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign ser_valid = (state_q == GRANT);
  assign ser_data  = ser_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Self-checking bench for sb_tx_arbiter: directed scenarios plus a randomized timeline model.
module tb_sb_tx_arbiter;

  localparam int N = 3;
  localparam int W = 128;
  localparam int G = 32;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, r0_valid, r0_ready;
  logic [N*W-1:0] req_data, r0_data;
  logic [W-1:0] ser_data, r0_ser_data;
  logic ser_valid, ser_ready, r0_ser_valid, r0_ser_ready;
  logic [1:0] grant_id, r0_grant_id;
  logic busy, r0_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sb_tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready), .grant_id(grant_id), .busy(busy)
  );

  sb_tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(r0_valid), .req_data(r0_data), .req_ready(r0_ready),
    .ser_data(r0_ser_data), .ser_valid(r0_ser_valid), .ser_ready(r0_ser_ready),
    .grant_id(r0_grant_id), .busy(r0_busy)
  );

  function automatic logic [W-1:0] rnd_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference arbitration rule: returns winner index or -1.
  function automatic int ref_pick(logic [N-1:0] v, int rr);
`ifdef SB_TX_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      automatic int i = (rr + k) % N;
`ifdef SB_TX_ARB_PRIO_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; r0_valid = '0; req_data = '0; r0_data = '0;
    ser_ready = 1'b0; r0_ser_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1; r0_valid = '1; req_data = '0; r0_data = '0;
    ser_ready = 1'b1; r0_ser_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
    checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL reset_ser_valid: got %b want 0", ser_valid); end
    checks++; if (ser_data !== '0) begin errors++; $display("FAIL reset_ser_data: got %h want 0", ser_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (r0_ready !== 3'b000) begin errors++; $display("FAIL reset_r0_ready: got %b want 000", r0_ready); end
    tick();
  endtask

  task automatic test_single();
    logic [W-1:0] pkt;
    int first;
    do_reset();
    pkt = {16{8'hA5}};
    ser_ready = 1'b1;
    req_data[W-1:0] = pkt;
    req_valid = 3'b001;
    @(negedge clk);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready_c0: got %b want 001", req_ready); end
    tick();
    req_data[W-1:0] = rnd_pkt();
    @(negedge clk);
    checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL single_ser_valid_c1: got %b want 1", ser_valid); end
    checks++; if (ser_data !== pkt) begin errors++; $display("FAIL single_ser_data: got %h want %h", ser_data, pkt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c1: got %b want 1", busy); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL single_ready_c1: got %b want 000", req_ready); end
    first = -1;
    for (int c = 2; c < 100; c++) begin
      tick();
      @(negedge clk);
      if (c == 2) begin
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL single_ser_valid_c2: got %b want 0", ser_valid); end
      end
      if (req_ready !== 3'b000) begin first = c; break; end
    end
    checks++; if (first != G + 2) begin errors++; $display("FAIL single_next_ready_cycle: got %0d want %0d", first, G + 2); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_all_valid();
    logic [W-1:0] pk [N];
    int exp_ord [4];
    int c;
`ifdef SB_TX_ARB_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 2, 0};
`endif
    do_reset();
    ser_ready = 1'b1;
    for (int i = 0; i < N; i++) begin pk[i] = rnd_pkt(); req_data[i*W +: W] = pk[i]; end
    req_valid = 3'b111;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      c = 0;
      while (req_ready == 3'b000 && c < 100) begin tick(); @(negedge clk); c++; end
      checks++; if (req_ready !== 3'(1 << exp_ord[n])) begin errors++; $display("FAIL all_ready[%0d]: got %b want %b", n, req_ready, 3'(1 << exp_ord[n])); end
      tick();
      pk[exp_ord[n]] = rnd_pkt();
      @(negedge clk);
      checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL all_ser_valid[%0d]: got %b want 1", n, ser_valid); end
      checks++; if (grant_id !== 2'(exp_ord[n])) begin errors++; $display("FAIL all_grant_id[%0d]: got %0d want %0d", n, grant_id, exp_ord[n]); end
      checks++; if (ser_data !== req_data[exp_ord[n]*W +: W]) begin errors++; $display("FAIL all_ser_data[%0d]: got %h want %h", n, ser_data, req_data[exp_ord[n]*W +: W]); end
      req_data[exp_ord[n]*W +: W] = pk[exp_ord[n]];
      tick();
      @(negedge clk);
      checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL all_ser_once[%0d]: got %b want 0", n, ser_valid); end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pkt;
    do_reset();
    pkt = rnd_pkt();
    req_data[W +: W] = pkt;
    req_valid = 3'b010;
    @(negedge clk);
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL bp_ready_c0: got %b want 010", req_ready); end
    tick();
    req_valid = 3'b111;
    for (int c = 1; c <= 10; c++) begin
      req_data = {rnd_pkt(), rnd_pkt(), rnd_pkt()};
      @(negedge clk);
      checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, ser_valid); end
      checks++; if (ser_data !== pkt) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h want %h", c, ser_data, pkt); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 000", c, req_ready); end
      tick();
    end
    ser_ready = 1'b1;
    @(negedge clk);
    checks++; if (ser_valid !== 1'b1 || ser_data !== pkt) begin errors++; $display("FAIL bp_accept_c11: got %b/%h want 1/%h", ser_valid, ser_data, pkt); end
    tick();
    @(negedge clk);
    checks++; if (ser_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 3'b000) begin errors++; $display("FAIL bp_after_accept: got v=%b busy=%b rdy=%b want 0/1/000", ser_valid, busy, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_gap();
    do_reset();
    ser_ready = 1'b1;
    req_data[W +: W] = rnd_pkt();
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    tick();
    repeat (15) tick();
    req_valid = 3'b110;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL rgap_pre: got busy=%b id=%0d want 1/1", busy, grant_id); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || ser_valid !== 1'b0 || req_ready !== 3'b000) begin errors++; $display("FAIL rgap_async: got busy=%b v=%b rdy=%b want 0/0/000", busy, ser_valid, req_ready); end
    checks++; if (ser_data !== '0 || grant_id !== 2'd0) begin errors++; $display("FAIL rgap_async_regs: got data=%h id=%0d want 0/0", ser_data, grant_id); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rgap_first_idle: got %b want 010", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_gap0();
    logic [W-1:0] exp_d;
    do_reset();
    exp_d = '0;
    r0_ser_ready = 1'b1;
    r0_data = {rnd_pkt(), rnd_pkt(), rnd_pkt()};
    r0_valid = 3'b011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (r0_ready !== ((c % 2 == 0) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL gap0_ready[%0d]: got %b", c, r0_ready); end
      checks++; if (r0_ser_valid !== (c % 2 == 1)) begin errors++; $display("FAIL gap0_ser_valid[%0d]: got %b want %b", c, r0_ser_valid, c % 2 == 1); end
      if (c % 2 == 1) begin
        checks++; if (r0_ser_data !== exp_d || r0_grant_id !== 2'd0) begin errors++; $display("FAIL gap0_data[%0d]: got %h id=%0d want %h id=0", c, r0_ser_data, r0_grant_id, exp_d); end
      end else begin
        exp_d = r0_data[W-1:0];
      end
      tick();
      r0_valid = 3'b001;
      r0_data[W-1:0] = rnd_pkt();
    end
    r0_valid = '0;
  endtask

`ifdef SB_TX_ARB_PRIO_EN
  task automatic test_prio();
    do_reset();
    r0_ser_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      r0_valid = {1'b1, 1'($urandom), 1'b1};
      @(negedge clk);
      if (c % 2 == 0) begin
        checks++; if (r0_ready !== 3'b001) begin errors++; $display("FAIL prio_req0[%0d]: got %b want 001", c, r0_ready); end
      end
      tick();
    end
    r0_valid = 3'b110;
    @(negedge clk);
    checks++; if (r0_ready !== 3'b010) begin errors++; $display("FAIL prio_rr_kept: got %b want 010", r0_ready); end
    tick(); tick();
    @(negedge clk);
    checks++; if (r0_ready !== 3'b100) begin errors++; $display("FAIL prio_rr_next: got %b want 100", r0_ready); end
    tick();
    r0_valid = '0;
  endtask
`endif

  // Timeline model: a grant holds the serializer until accepted, then the
  // arbiter is free again GAP+1 cycles after the accept cycle.
  task automatic test_random();
    int rr, gid, free_at, w;
    bit holding, idle;
    logic [W-1:0] m_data;
    logic [N-1:0] exp_rdy;
    do_reset();
`ifdef SB_TX_ARB_PRIO_EN
    rr = 1;
`else
    rr = 0;
`endif
    gid = 0; free_at = 0; holding = 0; m_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_valid = N'($urandom);
      req_data = {rnd_pkt(), rnd_pkt(), rnd_pkt()};
      ser_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      idle = !holding && (cyc >= free_at);
      w = idle ? ref_pick(req_valid, rr) : -1;
      exp_rdy = (w >= 0) ? N'(1 << w) : '0;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, req_ready, exp_rdy); end
      checks++; if (ser_valid !== holding) begin errors++; $display("FAIL rnd_ser_valid@%0d: got %b want %b", cyc, ser_valid, holding); end
      checks++; if (busy !== !idle) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, !idle); end
      checks++; if (grant_id !== 2'(gid)) begin errors++; $display("FAIL rnd_grant_id@%0d: got %0d want %0d", cyc, grant_id, gid); end
      if (holding) begin
        checks++; if (ser_data !== m_data) begin errors++; $display("FAIL rnd_ser_data@%0d: got %h want %h", cyc, ser_data, m_data); end
      end
      if (w >= 0) begin
        holding = 1;
        m_data = req_data[w*W +: W];
        gid = w;
`ifdef SB_TX_ARB_PRIO_EN
        if (w != 0) rr = (w == N - 1) ? 1 : w + 1;
`else
        rr = (w + 1) % N;
`endif
      end else if (holding && ser_ready) begin
        holding = 0;
        free_at = cyc + 1 + G;
      end
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_reset_mid_gap();
    test_gap0();
`ifdef SB_TX_ARB_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
